hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline stall and freeze controller for the 5-stage MIPS core. It sits beside the EXE-stage forwarding unit and covers what forwarding cannot:
- Detects in ID the data hazards that forwarding cannot resolve, and inserts bubbles for them.
- Freezes the whole pipeline while a variable-latency data-memory access in MEM is outstanding, with a timeout.
- Keeps a saturating stall-cycle statistic.

## Interface
Parameters:
- REG_W, 5, register-address width
- TIMEOUT, 64, max cycles to wait for mem_ready before aborting (≥2)
- CNT_W, 16, stall-statistic counter width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- src1_ID, src2_ID  in  REG_W  source registers of the instruction in ID
- two_src_ID  in  1  src2_ID is actually read (R-type or store)
- dest_EXE  in  REG_W  destination register in EXE
- WB_EN_EXE, MEM_R_EN_EXE  in  1 each  EXE writes back; EXE is a load
- dest_MEM  in  REG_W  destination register in MEM
- WB_EN_MEM  in  1  MEM writes back
- MEM_R_EN_MEM, MEM_W_EN_MEM  in  1 each  MEM stage performs a load or store
- forward_EN  in  1  forwarding unit enabled
- mem_ready  in  1  data memory completes the current access this cycle
- stall_IF_ID  out  1  hold PC and the IF/ID register
- bubble_ID_EXE  out  1  load a NOP into ID/EXE
- freeze_all  out  1  hold PC and all pipeline registers
- mem_req  out  1  access request to data memory
- mem_timeout  out  1  one-cycle pulse: the access was aborted
- mem_err  out  1  sticky; set on any timeout
- stall_cycles  out  CNT_W  saturating count of stalled or frozen cycles

## Operation
Register match:
- hit(d) = (src1_ID==d) OR (two_src_ID AND src2_ID==d).
- Register 0 never matches.

Data hazard (combinational):
- forward_EN=1: haz = WB_EN_EXE AND MEM_R_EN_EXE AND hit(dest_EXE). This is load-use only.
- forward_EN=0: haz = (WB_EN_EXE AND hit(dest_EXE)) OR (WB_EN_MEM AND hit(dest_MEM)).

Memory FSM, states IDLE and WAIT (encodings in defines.v). Let acc = MEM_R_EN_MEM OR MEM_W_EN_MEM.
- IDLE:
  - acc AND NOT mem_ready → WAIT, with wait_cnt←1.
  - acc AND mem_ready → stay in IDLE. This is a zero-wait access.
- WAIT:
  - mem_ready → IDLE.
  - wait_cnt==TIMEOUT-1 AND NOT mem_ready → IDLE, with a mem_timeout pulse next cycle and mem_err←1.
  - Otherwise wait_cnt←wait_cnt+1.

Outputs:
- mem_req = acc in IDLE, and 1 throughout WAIT.
- freeze_all = (acc AND NOT mem_ready AND state==IDLE) OR (state==WAIT AND NOT mem_ready AND NOT timeout_hit), where timeout_hit = (wait_cnt==TIMEOUT-1).
- On the timeout cycle freeze_all is 0: the access is treated as complete and the pipeline advances.
- Priority: freeze_all=1 forces stall_IF_ID=0 and bubble_ID_EXE=0. A frozen pipeline does not also bubble. A data hazard present during a freeze is re-evaluated once the freeze drops.
- When not frozen, stall_IF_ID = bubble_ID_EXE = haz.

stall_cycles:
- Increments on every cycle with freeze_all OR haz-stall.
- Saturates at all-ones.

## Timing
- stall_IF_ID, bubble_ID_EXE, freeze_all and mem_req are Mealy outputs: they are valid in the same cycle as their inputs, with zero latency.
- Load-use costs exactly 1 bubble when forward_EN=1. After the bubble the load reaches MEM and forwarding covers the rest.
- With forward_EN=0, a dependency on EXE costs 2 bubbles and a dependency on MEM costs 1.
- An access with k wait cycles costs k frozen cycles. mem_ready arriving in cycle k releases the freeze in that same cycle.
- Back-to-back accesses: after mem_ready the FSM is in IDLE on the next edge, and the next MEM access is evaluated fresh.
- mem_ready while not in WAIT and with no acc is ignored.
- Reset (asynchronous, active-low):
  - State values: state=IDLE, wait_cnt=0, mem_timeout=0, mem_err=0, stall_cycles=0.
  - While rst_n=0 all combinational outputs are forced to 0.
  - Asserting reset mid-WAIT abandons the access without raising mem_timeout.

## Structure
- defines.v gains the FSM state encodings (IDLE, WAIT) and the REG_ZERO constant.
- Sub-module mem_wait_timer holds wait_cnt, the timeout compare, and the mem_timeout/mem_err registers. It is driven by start, active and done inputs.
- Hazard compare and output priority stay in the top module.

## Test plan
- Load-use: forward_EN=1, EXE = lw writing $5, ID reads src1=$5 → stall_IF_ID=bubble_ID_EXE=1 for exactly 1 cycle. The same case with src1=$0 → no stall.
- No forwarding: forward_EN=0, EXE add writing $3, ID reads src2=$3 with two_src_ID=1 → bubble for 2 consecutive cycles (EXE match, then MEM match). With two_src_ID=0 → no stall.
- Memory wait: MEM lw, mem_ready low for 3 cycles then high → freeze_all=1 for 3 cycles and 0 on the ready cycle. mem_req=1 for 4 cycles. stall_cycles increases by 3.
- Timeout: TIMEOUT=4, mem_ready never rises → freeze_all=1 for 3 cycles, then 0. mem_timeout pulses once, mem_err stays 1.
- Freeze priority: a load-use hazard is present in ID while MEM waits 2 cycles → bubble_ID_EXE=0 during the freeze, then 1 for one cycle after release.
- Reset mid-WAIT and saturation: rst_n is pulsed low during WAIT → all outputs 0 and no timeout pulse. With CNT_W=4 and a long stall, stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared FSM encodings and constants for the stall controller
package hazard_stall_ctrl_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} mem_state_t;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline-side hazard inputs and stall/freeze outputs
interface hazard_stall_ctrl_if
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic two_src_ID, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM;
  logic MEM_R_EN_MEM, MEM_W_EN_MEM, forward_EN, mem_ready;
  logic stall_IF_ID, bubble_ID_EXE, freeze_all, mem_req, mem_timeout, mem_err;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output src1_ID, src2_ID, two_src_ID, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
    output dest_MEM, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM, forward_EN, mem_ready,
    input  stall_IF_ID, bubble_ID_EXE, freeze_all, mem_req, mem_timeout, mem_err, stall_cycles
  );
  modport slave (
    input  src1_ID, src2_ID, two_src_ID, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
    input  dest_MEM, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM, forward_EN, mem_ready,
    output stall_IF_ID, bubble_ID_EXE, freeze_all, mem_req, mem_timeout, mem_err, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles, flags the timeout and keeps the error latch
module mem_wait_timer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_active,
  input  logic i_done,
  output logic o_timeout_hit,
  output logic o_mem_timeout,
  output logic o_mem_err
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] r_wait_cnt;
  logic r_mem_timeout, r_mem_err;
  logic w_abort;
  assign o_timeout_hit = i_active && r_wait_cnt == CW'(TIMEOUT - 1);
  assign w_abort       = o_timeout_hit && !i_done;
  assign o_mem_timeout = r_mem_timeout;
  assign o_mem_err     = r_mem_err;
  // wait counter restarts at 1 on a new stalled access and clears whenever the access ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_mem_err     <= 1'b0;
    end else begin
      r_wait_cnt    <= i_start ? CW'(1) : (i_active && !i_done && !o_timeout_hit) ? r_wait_cnt + 1'b1 : '0;
      r_mem_timeout <= w_abort;
      r_mem_err     <= r_mem_err || w_abort;
    end
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use/no-forward bubbles, memory-wait freeze with timeout, stall statistic
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_stall_ctrl_if.slave bus
);
  mem_state_t r_state, w_next;
  logic [CNT_W-1:0] r_stall_cycles;
  logic w_acc, w_idle, w_start, w_timeout_hit, w_mem_timeout, w_mem_err;
  logic w_hit_exe, w_hit_mem, w_haz, w_freeze, w_stall;
  function automatic logic hit(input logic [REG_W-1:0] d, s1, s2, input logic two);
    return d != REG_W'(REG_ZERO) && (s1 == d || (two && s2 == d));
  endfunction
  assign w_acc     = bus.MEM_R_EN_MEM || bus.MEM_W_EN_MEM;
  assign w_idle    = r_state == S_IDLE;
  assign w_start   = w_idle && w_acc && !bus.mem_ready;
  assign w_hit_exe = hit(bus.dest_EXE, bus.src1_ID, bus.src2_ID, bus.two_src_ID);
  assign w_hit_mem = hit(bus.dest_MEM, bus.src1_ID, bus.src2_ID, bus.two_src_ID);
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (w_start),
    .i_active      (!w_idle),
    .i_done        (bus.mem_ready),
    .o_timeout_hit (w_timeout_hit),
    .o_mem_timeout (w_mem_timeout),
    .o_mem_err     (w_mem_err)
  );
  // memory access state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next state, hazard detection and freeze-over-bubble priority; everything held low in reset
  always_comb begin
    w_next   = w_idle ? (w_start ? S_WAIT : S_IDLE) : ((bus.mem_ready || w_timeout_hit) ? S_IDLE : S_WAIT);
    w_haz    = rst_n && (bus.forward_EN ? (bus.WB_EN_EXE && bus.MEM_R_EN_EXE && w_hit_exe)
                                        : ((bus.WB_EN_EXE && w_hit_exe) || (bus.WB_EN_MEM && w_hit_mem)));
    w_freeze = rst_n && (w_idle ? w_start : (!bus.mem_ready && !w_timeout_hit));
    w_stall  = w_haz && !w_freeze;
  end
  // saturating count of cycles lost to freezes or bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stall_cycles <= '0;
    else if ((w_freeze || w_stall) && r_stall_cycles != {CNT_W{1'b1}}) r_stall_cycles <= r_stall_cycles + 1'b1;
  end
  assign bus.stall_IF_ID   = w_stall;
  assign bus.bubble_ID_EXE = w_stall;
  assign bus.freeze_all    = w_freeze;
  assign bus.mem_req       = rst_n && (w_idle ? w_acc : 1'b1);
  assign bus.mem_timeout   = w_mem_timeout;
  assign bus.mem_err       = w_mem_err;
  assign bus.stall_cycles  = r_stall_cycles;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed test-plan steps plus random traffic against a cycle model
module tb_hazard_stall_ctrl;
  localparam int TO = 4;
  logic clk, rst_n;
  int total = 0, bad = 0;
  int m_wait = 0;
  bit m_to = 0, m_err = 0;
  int m_cnt = 0;
  hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4)) bus ();
  hazard_stall_ctrl #(.REG_W(5), .TIMEOUT(TO), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic bit hit(input logic [4:0] d);
    return d != 0 && (bus.src1_ID == d || (bus.two_src_ID && bus.src2_ID == d));
  endfunction
  task automatic set(input bit f, input logic [4:0] s1, s2, input bit two, input logic [4:0] de,
                     input bit we, re, input logic [4:0] dm, input bit wm, rm, wrm, rdy);
    bus.forward_EN = f; bus.src1_ID = s1; bus.src2_ID = s2; bus.two_src_ID = two;
    bus.dest_EXE = de; bus.WB_EN_EXE = we; bus.MEM_R_EN_EXE = re;
    bus.dest_MEM = dm; bus.WB_EN_MEM = wm; bus.MEM_R_EN_MEM = rm; bus.MEM_W_EN_MEM = wrm;
    bus.mem_ready = rdy;
  endtask
  task automatic cyc();
    bit acc, busy, hz, fz, st, to;
    acc  = bus.MEM_R_EN_MEM || bus.MEM_W_EN_MEM;
    busy = m_wait != 0;
    hz   = bus.forward_EN ? (bus.WB_EN_EXE && bus.MEM_R_EN_EXE && hit(bus.dest_EXE))
                          : ((bus.WB_EN_EXE && hit(bus.dest_EXE)) || (bus.WB_EN_MEM && hit(bus.dest_MEM)));
    fz   = busy ? (!bus.mem_ready && m_wait != TO - 1) : (acc && !bus.mem_ready);
    st   = hz && !fz;
    to   = busy && !bus.mem_ready && m_wait == TO - 1;
    #2;
    chk("stall_IF_ID", bus.stall_IF_ID, st);
    chk("bubble_ID_EXE", bus.bubble_ID_EXE, st);
    chk("freeze_all", bus.freeze_all, fz);
    chk("mem_req", bus.mem_req, busy || acc);
    chk("mem_timeout", bus.mem_timeout, m_to);
    chk("mem_err", bus.mem_err, m_err);
    chk("stall_cycles", bus.stall_cycles, m_cnt);
    @(posedge clk);
    if (!busy && acc && !bus.mem_ready) m_wait = 1;
    else if (busy) m_wait = (bus.mem_ready || to) ? 0 : m_wait + 1;
    m_to  = to;
    m_err = m_err || to;
    if ((fz || st) && m_cnt < 15) m_cnt++;
    #1;
  endtask
  task automatic model_reset();
    m_wait = 0; m_to = 0; m_err = 0; m_cnt = 0;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_stall"}, bus.stall_IF_ID, 0);
    chk({tag, "_bubble"}, bus.bubble_ID_EXE, 0);
    chk({tag, "_freeze"}, bus.freeze_all, 0);
    chk({tag, "_req"}, bus.mem_req, 0);
    chk({tag, "_timeout"}, bus.mem_timeout, 0);
    chk({tag, "_err"}, bus.mem_err, 0);
    chk({tag, "_cnt"}, bus.stall_cycles, 0);
  endtask
  initial begin
    rst_n = 0;
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    all_zero("reset");
    rst_n = 1;
    // load-use with forwarding: one bubble, then the load is in MEM
    set(1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1); cyc();
    set(1, 5, 0, 0, 0, 0, 0, 5, 1, 1, 0, 1); cyc();
    set(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1); cyc();
    // no forwarding: EXE match then MEM match
    set(0, 1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 1); cyc();
    set(0, 1, 3, 1, 0, 0, 0, 3, 1, 0, 0, 1); cyc();
    set(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    set(0, 1, 3, 0, 3, 1, 0, 3, 1, 0, 0, 1); cyc();
    // memory wait: 3 stalled cycles then ready
    for (int i = 0; i < 3; i++) begin
      set(1, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0); cyc();
    end
    set(1, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 1); cyc();
    chk("memwait_cnt", bus.stall_cycles, 6);
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    // freeze priority over a pending load-use hazard
    for (int i = 0; i < 2; i++) begin
      set(1, 7, 0, 0, 7, 1, 1, 2, 0, 0, 1, 0); cyc();
    end
    set(1, 7, 0, 0, 7, 1, 1, 2, 0, 0, 1, 1); cyc();
    set(1, 7, 0, 0, 0, 0, 0, 7, 1, 1, 0, 1); cyc();
    // timeout: ready never comes
    for (int i = 0; i < TO; i++) begin
      set(1, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0, 0); cyc();
    end
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("timeout_err_sticky", bus.mem_err, 1);
    cyc();
    // reset while waiting abandons the access silently
    set(1, 0, 0, 0, 0, 0, 0, 6, 1, 1, 0, 0); cyc();
    rst_n = 0;
    #2;
    model_reset();
    all_zero("rst_wait");
    @(posedge clk); #1;
    all_zero("rst_hold");
    rst_n = 1;
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    // long freeze drives the counter into saturation
    for (int i = 0; i < 24; i++) begin
      set(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0); cyc();
    end
    chk("saturate", bus.stall_cycles, 15);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 0; #1; model_reset(); rst_n = 1;
      end
      set($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1),
          5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
          5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
